reorder_buffer: RTL
===================

# reorder_buffer

8-entry circular reorder buffer for the Tomasulo out-of-order core. It answers decode's allocation requests with a tag and exports per-entry state and values so decode can forward operands. It captures results from the memory and integer CDBs and retires entries in program order, one per cycle, to the register file, register-status table and store path. Entries marked speculative are either squashed or confirmed by branch resolution.

## Interface
Parameters:
- DEPTH, 8: entry count; fixed at 8 because tags are 3 bits.
- XLEN, 32: data width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- alloc_req  in  1  decode requests one entry this cycle.
- alloc_S  in  1  new entry is speculative.
- alloc_ST  in  1  new entry is a store.
- alloc_V  in  1  new entry writes a register.
- alloc_rd  in  5  destination register.
- alloc_gnt  out  1  combinational: alloc_req & ~rob_full & ~flush.
- alloc_tag  out  3  combinational: current tail index; valid whether or not granted.
- rob_full  out  1  count == 8.
- mem_CDB_valid/mem_CDB_id/mem_CDB_value  in  1/3/32  memory CDB result.
- int_CDB_valid/int_CDB_id/int_CDB_value  in  1/3/32  integer CDB result.
- dump_state  out  16  2 bits per entry; entry i occupies [2i+1:2i]. Encoding: 00 free, 01 pending, 10 ready, 11 never produced.
- dump_value  out  256  32 bits per entry; entry i occupies [32i+31:32i].
- flush  in  1  squash all S=1 entries.
- spec_clear  in  1  clear S on all entries.
- commit_valid  out  1  head retires at this edge.
- commit_tag  out  3  head index.
- commit_rd  out  5  head destination.
- commit_value  out  32  head value.
- commit_we  out  1  commit_valid & V.
- commit_store  out  1  commit_valid & ST.

## Operation
- Per-entry storage: state[1:0], S, ST, V, rd[4:0], value[31:0]. Pointers head[2:0] and tail[2:0]; counter count[3:0] runs 0..8.
- Allocate when alloc_gnt is high. At the edge: entry[tail] gets state=01, S/ST/V/rd from the alloc inputs, value=0; tail increments mod 8 and count increments.
- CDB capture: each valid CDB whose id addresses a state-01 entry sets that entry to 10 and latches the CDB value. Both CDBs may complete different entries in the same cycle. If both carry the same id, the mem value wins. A CDB aimed at a free or ready entry is ignored.
- Commit: commit_valid = (state[head]==10) & ~S[head] & ~flush. It is combinational from head. At the edge the head entry becomes 00, head increments, and count decrements.
  - The register-status table clears rd only if its stored tag equals {1,commit_tag}.
  - The store unit performs its memory write on commit_store.
- Alloc and commit in the same cycle: both happen and count is unchanged. When full, a commit frees a slot for the next cycle, not the current one.
- flush: every S=1 entry becomes free. tail moves back by the number of S=1 entries, which are always the contiguous youngest. count is reduced by the same number.
  - Any alloc presented in the flush cycle is ignored (alloc_gnt is low).
  - CDB writes to squashed entries in that cycle are dropped.
- spec_clear: all S bits clear at the edge. If flush and spec_clear arrive together, flush wins.
- An S=1 head blocks commit until spec_clear or flush.

## Timing
- Reset values: all entries at state 00 with S/ST/V/rd/value = 0; head=tail=0; count=0. So rob_full=0, alloc_tag=0, dump_state=0, dump_value=0, and all commit_* outputs are 0.
- Allocation latency: 0 cycles for the tag (same-cycle handshake); the entry shows 01 in dump_state after the edge.
- CDB to dump_state=10: 1 cycle. Decode covers the capture cycle by comparing against the CDB directly.
- Ready to commit: the first edge at which the entry is head, ready and S=0. Throughput is 1 retire per cycle.
- Pointer wrap: 7→0 for head and tail. Full is count==8 with head==tail. Empty is count==0 with head==tail.
- Asynchronous rst mid-operation returns everything to the reset values immediately. Pending CDB results are lost.

## Test plan
- Reset, then alloc 3 entries (rd=5,6,7, V=1): tags 0,1,2 are granted; dump_state=0x0015. Then int CDB id=1 value=0xAB: dump_state=0x0019; no commit, because head 0 is pending.
- Fill 8 entries: rob_full=1 and alloc_gnt=0 with alloc_req=1. Complete head via the mem CDB: the next edge commits tag 0 with commit_we=1, and rob_full drops the following cycle.
- Both CDBs in the same cycle (ids 2 and 4, values 0x11 and 0x22): both entries become 10 with their values. Same id 3 on both: the mem value is stored.
- Wrap: 20 alloc/complete/commit cycles at steady occupancy. Commits occur in order with tags cycling 0..7 repeatedly, and count stays constant.
- Alloc tags 0,1 non-speculative, then tags 2,3 with S=1, then flush: entries 2 and 3 are freed and the next alloc gets tag 2. Repeat the setup with spec_clear instead: tags 2 and 3 commit normally.
- Store entry (ST=1, V=0) completes: commit_store=1 and commit_we=0. Assert rst while occupied: all outputs return to 0 immediately.

Source files
------------

// File: rtl/reorder_buffer.sv
// reorder_buffer
//   8-entry circular reorder buffer. Decode allocates entries at the tail.
//   Results arrive on the memory and integer CDBs. Entries retire from the
//   head in program order, one per cycle. Branch resolution either squashes
//   the speculative entries (flush) or confirms them (spec_clear).
//
//   Entry state encoding:
//     state | meaning
//     00    | free
//     01    | allocated, result pending
//     10    | result captured, ready to retire
//     11    | never produced
//
// Ports
//   clk, rst                        clock; asynchronous active-high reset
//   alloc_req/S/ST/V/rd             allocation request and entry attributes
//   alloc_gnt, alloc_tag            same-cycle grant and tail index
//   rob_full                        all 8 entries occupied
//   mem_CDB_*, int_CDB_*            result buses (valid, id, value)
//   dump_state, dump_value          per-entry state/value for operand forwarding
//   flush, spec_clear               branch resolution: squash / confirm
//   commit_*                        head retirement info (combinational)
module reorder_buffer #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alloc_req,
  input  logic                    alloc_S,
  input  logic                    alloc_ST,
  input  logic                    alloc_V,
  input  logic [4:0]              alloc_rd,
  output logic                    alloc_gnt,
  output logic [2:0]              alloc_tag,
  output logic                    rob_full,
  input  logic                    mem_CDB_valid,
  input  logic [2:0]              mem_CDB_id,
  input  logic [XLEN-1:0]         mem_CDB_value,
  input  logic                    int_CDB_valid,
  input  logic [2:0]              int_CDB_id,
  input  logic [XLEN-1:0]         int_CDB_value,
  output logic [2*DEPTH-1:0]      dump_state,
  output logic [XLEN*DEPTH-1:0]   dump_value,
  input  logic                    flush,
  input  logic                    spec_clear,
  output logic                    commit_valid,
  output logic [2:0]              commit_tag,
  output logic [4:0]              commit_rd,
  output logic [XLEN-1:0]         commit_value,
  output logic                    commit_we,
  output logic                    commit_store
);

  localparam logic [1:0] ST_FREE  = 2'b00;
  localparam logic [1:0] ST_PEND  = 2'b01;
  localparam logic [1:0] ST_READY = 2'b10;

  logic [1:0]      state_q [DEPTH];
  logic            spec_q  [DEPTH];
  logic            st_q    [DEPTH];
  logic            v_q     [DEPTH];
  logic [4:0]      rd_q    [DEPTH];
  logic [XLEN-1:0] value_q [DEPTH];

  logic [2:0] head_q;
  logic [2:0] tail_q;
  logic [3:0] count_q;
  logic [3:0] squash_cnt;
  logic [3:0] squash_dec;

  assign rob_full     = (count_q == 4'd8);
  assign alloc_gnt    = alloc_req & ~rob_full & ~flush;
  assign alloc_tag    = tail_q;

  assign commit_valid = (state_q[head_q] == ST_READY) & ~spec_q[head_q] & ~flush;
  assign commit_tag   = head_q;
  assign commit_rd    = rd_q[head_q];
  assign commit_value = value_q[head_q];
  assign commit_we    = commit_valid & v_q[head_q];
  assign commit_store = commit_valid & st_q[head_q];

  for (genvar g = 0; g < DEPTH; g++) begin : g_dump
    assign dump_state[2*g +: 2]       = state_q[g];
    assign dump_value[XLEN*g +: XLEN] = value_q[g];
  end

  // Speculative entries are always the youngest contiguous block, so
  // rewinding the tail by their number lands just after the last survivor.
  always_comb begin
    squash_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (spec_q[i] && (state_q[i] != ST_FREE)) squash_cnt = squash_cnt + 4'd1;
    end
  end

  assign squash_dec = flush ? squash_cnt : 4'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= ST_FREE;
        spec_q[i]  <= 1'b0;
        st_q[i]    <= 1'b0;
        v_q[i]     <= 1'b0;
        rd_q[i]    <= '0;
        value_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (flush && spec_q[i] && (state_q[i] != ST_FREE)) begin
          // Squashed entries drop any CDB result arriving this cycle.
          state_q[i] <= ST_FREE;
          spec_q[i]  <= 1'b0;
          st_q[i]    <= 1'b0;
          v_q[i]     <= 1'b0;
          rd_q[i]    <= '0;
          value_q[i] <= '0;
        end else begin
          if (spec_clear && !flush) spec_q[i] <= 1'b0;
          // Only pending entries capture; mem has priority on an id clash.
          if (state_q[i] == ST_PEND) begin
            if (mem_CDB_valid && (mem_CDB_id == 3'(i))) begin
              state_q[i] <= ST_READY;
              value_q[i] <= mem_CDB_value;
            end else if (int_CDB_valid && (int_CDB_id == 3'(i))) begin
              state_q[i] <= ST_READY;
              value_q[i] <= int_CDB_value;
            end
          end
        end
      end

      // The head entry is ready and the tail entry is free, so neither
      // override below collides with a capture or a squash above.
      if (commit_valid) begin
        state_q[head_q] <= ST_FREE;
        spec_q[head_q]  <= 1'b0;
        st_q[head_q]    <= 1'b0;
        v_q[head_q]     <= 1'b0;
        rd_q[head_q]    <= '0;
        value_q[head_q] <= '0;
        head_q          <= head_q + 3'd1;
      end

      if (alloc_gnt) begin
        state_q[tail_q] <= ST_PEND;
        spec_q[tail_q]  <= alloc_S;
        st_q[tail_q]    <= alloc_ST;
        v_q[tail_q]     <= alloc_V;
        rd_q[tail_q]    <= alloc_rd;
        value_q[tail_q] <= '0;
      end

      // Squash count of 8 wraps to 0 in the 3-bit tail, which is correct.
      tail_q  <= tail_q + {2'b00, alloc_gnt} - squash_dec[2:0];
      count_q <= count_q + {3'b000, alloc_gnt} - {3'b000, commit_valid} - squash_dec;
    end
  end

endmodule
